// File: rtl/multi_frame_buffer_if.sv
// Interface bundling the writer, reader and status signals of multi_frame_buffer.
// The master side is the writer/reader pair; the slave side is the buffer.
`default_nettype none

interface multi_frame_buffer_if #(
  parameter int ADDRESS_DEPTH = 512,
  parameter int BANK_COUNT    = 3,
  parameter int DATA_WIDTH    = 128,
  parameter int BUFFER_COUNT  = 3,
  parameter int CNT_WIDTH     = 16
) ();
  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int BW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
  localparam int IW = $clog2(BUFFER_COUNT);

  logic                             wr_en;
  logic [BW-1:0]                    wr_bank;
  logic [AW-1:0]                    wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             frame_commit;
  logic                             write_ready;
  logic                             rd_en;
  logic [AW-1:0]                    rd_addr;
  logic [BANK_COUNT*DATA_WIDTH-1:0] rd_data_flat;
  logic                             rd_valid;
  logic                             frame_start;
  logic                             data_valid;
  logic [IW-1:0]                    wr_buf_idx;
  logic [IW-1:0]                    rd_buf_idx;
  logic [CNT_WIDTH-1:0]             frames_dropped;
  logic [CNT_WIDTH-1:0]             frames_repeated;
  logic                             wr_overrun;

  modport master (
    output wr_en, wr_bank, wr_addr, wr_data, frame_commit,
    output rd_en, rd_addr, frame_start,
    input  write_ready, rd_data_flat, rd_valid, data_valid,
    input  wr_buf_idx, rd_buf_idx, frames_dropped, frames_repeated, wr_overrun
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_data, frame_commit,
    input  rd_en, rd_addr, frame_start,
    output write_ready, rd_data_flat, rd_valid, data_valid,
    output wr_buf_idx, rd_buf_idx, frames_dropped, frames_repeated, wr_overrun
  );
endinterface

`default_nettype wire

// File: rtl/multi_frame_buffer.sv
// N-way (2..4) banked frame buffer with write/pending/read buffer rotation,
// writer back-pressure for two buffers, and dropped/repeated frame statistics.
`default_nettype none

module multi_frame_buffer #(
  parameter int ADDRESS_DEPTH = 512,
  parameter int BANK_COUNT    = 3,
  parameter int DATA_WIDTH    = 128,
  parameter int BUFFER_COUNT  = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst,
  multi_frame_buffer_if.slave bus_if
);
  localparam int BW        = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
  localparam int IW        = $clog2(BUFFER_COUNT);
  localparam int MEM_DEPTH = BUFFER_COUNT * ADDRESS_DEPTH;
  localparam bit TWO_BUF   = (BUFFER_COUNT == 2);

  generate
    if (BUFFER_COUNT < 2 || BUFFER_COUNT > 4) begin : g_bad_count
      $error("multi_frame_buffer: BUFFER_COUNT must be 2..4");
    end
  endgenerate

  logic [IW-1:0]        r_wr_idx, r_rd_idx, r_pend_idx;
  logic                 r_pend_vld, r_write_ready, r_data_valid, r_rd_valid, r_overrun;
  logic [CNT_WIDTH-1:0] r_dropped, r_repeated;

  logic [IW-1:0]        w_wr_nxt, w_rd_nxt, w_pend_nxt;
  logic                 w_pend_vld_nxt, w_write_ready_nxt, w_data_valid_nxt;
  logic                 w_write, w_commit, w_drop, w_repeat, w_overrun_evt;

  function automatic logic [IW-1:0] f_lowest_free(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW-1:0] v;
    v = '0;
    for (int i = BUFFER_COUNT - 1; i >= 0; i--) begin
      if (IW'(i) != a && IW'(i) != b) v = IW'(i);
    end
    return v;
  endfunction

  assign w_write       = bus_if.wr_en && r_write_ready;
  assign w_commit      = bus_if.frame_commit && r_write_ready;
  assign w_overrun_evt = (bus_if.wr_en || bus_if.frame_commit) && !r_write_ready;

  // Commit is resolved before frame_start when both arrive together.
  always_comb begin
    w_wr_nxt          = r_wr_idx;
    w_rd_nxt          = r_rd_idx;
    w_pend_nxt        = r_pend_idx;
    w_pend_vld_nxt    = r_pend_vld;
    w_write_ready_nxt = r_write_ready;
    w_data_valid_nxt  = r_data_valid;
    w_drop            = 1'b0;
    w_repeat          = 1'b0;
    if (w_commit && bus_if.frame_start) begin
      w_rd_nxt         = r_wr_idx;
      w_drop           = r_pend_vld;
      w_pend_vld_nxt   = 1'b0;
      w_data_valid_nxt = 1'b1;
      w_wr_nxt         = TWO_BUF ? r_rd_idx : f_lowest_free(r_wr_idx, r_wr_idx);
    end else if (w_commit) begin
      w_pend_nxt     = r_wr_idx;
      w_pend_vld_nxt = 1'b1;
      if (TWO_BUF) begin
        w_write_ready_nxt = 1'b0;
      end else begin
        w_drop   = r_pend_vld;
        w_wr_nxt = f_lowest_free(r_rd_idx, r_wr_idx);
      end
    end else if (bus_if.frame_start) begin
      if (r_pend_vld) begin
        w_rd_nxt         = r_pend_idx;
        w_pend_vld_nxt   = 1'b0;
        w_data_valid_nxt = 1'b1;
        if (TWO_BUF) begin
          w_wr_nxt          = r_rd_idx;
          w_write_ready_nxt = 1'b1;
        end
      end else begin
        w_repeat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx      <= '0;
      r_rd_idx      <= IW'(BUFFER_COUNT - 1);
      r_pend_idx    <= '0;
      r_pend_vld    <= 1'b0;
      r_write_ready <= 1'b1;
      r_data_valid  <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_dropped     <= '0;
      r_repeated    <= '0;
    end else begin
      r_wr_idx      <= w_wr_nxt;
      r_rd_idx      <= w_rd_nxt;
      r_pend_idx    <= w_pend_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_write_ready <= w_write_ready_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_rd_valid    <= bus_if.rd_en;
      if (w_overrun_evt) r_overrun <= 1'b1;
      if (w_drop && r_dropped != {CNT_WIDTH{1'b1}}) r_dropped <= r_dropped + CNT_WIDTH'(1);
      if (w_repeat && r_repeated != {CNT_WIDTH{1'b1}}) r_repeated <= r_repeated + CNT_WIDTH'(1);
    end
  end

  // Memory is indexed {buffer, address}; contents survive reset.
  genvar b;
  generate
    for (b = 0; b < BANK_COUNT; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
      logic [DATA_WIDTH-1:0] r_rd_word;

      always_ff @(posedge clk) begin
        if (w_write && bus_if.wr_bank == BW'(b)) begin
          r_mem[{r_wr_idx, bus_if.wr_addr}] <= bus_if.wr_data;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_word <= '0;
        end else if (bus_if.rd_en) begin
          r_rd_word <= r_mem[{r_rd_idx, bus_if.rd_addr}];
        end
      end

      assign bus_if.rd_data_flat[b*DATA_WIDTH +: DATA_WIDTH] = r_rd_word;
    end
  endgenerate

  assign bus_if.write_ready     = r_write_ready;
  assign bus_if.data_valid      = r_data_valid;
  assign bus_if.rd_valid        = r_rd_valid;
  assign bus_if.wr_buf_idx      = r_wr_idx;
  assign bus_if.rd_buf_idx      = r_rd_idx;
  assign bus_if.frames_dropped  = r_dropped;
  assign bus_if.frames_repeated = r_repeated;
  assign bus_if.wr_overrun      = r_overrun;
endmodule

`default_nettype wire
